// File: rtl/pps_pulse_gen.sv
// Periodic PPS-style pulse generator with start tick and pulse counter.
// Build option: define PPS_GEN_TRIM_EN to add the signed per-period trim input.
//
// state  | meaning
// S_IDLE | disabled, pps_out low, counter cleared
// S_HIGH | pulse high portion of the period
// S_LOW  | pulse low portion, period ends when cnt reaches p_l
module pps_pulse_gen #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic [CNT_W-1:0] period_m1,
  input  logic [CNT_W-1:0] width,
  input  logic             resync,
`ifdef PPS_GEN_TRIM_EN
  input  logic [7:0]       trim,
`endif
  output logic             pps_out,
  output logic             tick,
  output logic [CNT_W-1:0] sec_count
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] p_l;
  logic [CNT_W-1:0] w_l;
  logic [CNT_W-1:0] p_nx;
  logic [CNT_W-1:0] w_nx;
  logic             do_start;

`ifdef PPS_GEN_TRIM_EN
  // Two guard bits: the top one flags a negative sum, the next one an overflow,
  // which saturates rather than wrapping into a short period.
  logic [CNT_W+1:0] p_sum;

  always_comb begin
    p_sum = {2'b00, period_m1} + {{(CNT_W-6){trim[7]}}, trim};
    if (p_sum[CNT_W+1] || (p_sum == '0))
      p_nx = ONE;
    else if (p_sum[CNT_W])
      p_nx = '1;
    else
      p_nx = p_sum[CNT_W-1:0];
  end
`else
  always_comb begin
    p_nx = (period_m1 == '0) ? ONE : period_m1;
  end
`endif

  // Clamping width to p_l leaves at least one low clock in every period.
  always_comb begin
    w_nx = (width > p_nx) ? p_nx : width;
  end

  always_comb begin
    do_start = 1'b0;
    case (state)
      S_IDLE:  do_start = enable;
      S_HIGH:  do_start = enable && resync;
      S_LOW:   do_start = enable && (resync || (cnt == p_l));
      default: do_start = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      p_l       <= '0;
      w_l       <= '0;
      pps_out   <= 1'b0;
      tick      <= 1'b0;
      sec_count <= '0;
    end else begin
      tick <= do_start;
      if (do_start) begin
        cnt       <= '0;
        sec_count <= sec_count + ONE;
        p_l       <= p_nx;
        w_l       <= w_nx;
        pps_out   <= (w_nx != '0);
        state     <= (w_nx != '0) ? S_HIGH : S_LOW;
      end else if (!enable || (state == S_IDLE)) begin
        state   <= S_IDLE;
        cnt     <= '0;
        pps_out <= 1'b0;
      end else if ((state == S_HIGH) && (cnt == w_l - ONE)) begin
        state   <= S_LOW;
        pps_out <= 1'b0;
        cnt     <= cnt + ONE;
      end else begin
        cnt <= cnt + ONE;
      end
    end
  end

endmodule
